aemb_icache: RTL and testbench
==============================

# aemb_icache

Direct-mapped, single-word-line instruction cache inserted between the AEMB core instruction Wishbone port and the external instruction bus. The core's fetch requests (iwb_stb_o/iwb_adr_o) terminate here. Hits are answered from on-chip tag/data RAM. Misses are forwarded as single-word Wishbone classic reads on the icb_* master port, then written into the cache. A flush sweep invalidates all lines at reset and on request.

## Interface
- AW, 32: address width; word address is [AW-1:2].
- CW, 8: index width; 2^CW lines of one 32-bit word; tag width TW = AW-2-CW.

Ports:
- sys_clk_i  in  1  clock, all logic on rising edge.
- sys_rst_i  in  1  reset, synchronous, active-high.
- iwb_stb_i  in  1  core fetch strobe; held with iwb_adr_i until iwb_ack_o.
- iwb_adr_i  in  AW-2  core fetch word address [AW-1:2].
- iwb_dat_o  out  32  instruction to core; valid when iwb_ack_o.
- iwb_ack_o  out  1  one-cycle fetch acknowledge.
- icb_stb_o  out  1  external read strobe (write-enable is never driven; read-only).
- icb_adr_o  out  AW-2  external word address.
- icb_dat_i  in  32  external read data.
- icb_ack_i  in  1  external acknowledge.
- ich_fls_i  in  1  flush request, single-cycle pulse sufficient.
- ich_bsy_o  out  1  high while flush sweep is active.

## Operation
- Address split: index = iwb_adr_i[CW+1:2], tag = iwb_adr_i[AW-1:CW+2].
- Storage: tag RAM (TW+1 bits incl. valid) and data RAM (32 bits), 2^CW deep, synchronous read, one write port.
- FSM states: FLUSH, IDLE, CMP, FILL, DONE.
- FLUSH: sweep counter idx from 0 to 2^CW-1, writes valid=0 at idx each cycle; ich_bsy_o=1; iwb_stb_i ignored, icb_ack_i ignored. At idx=2^CW-1 → IDLE; counter wraps to 0.
- IDLE: if flush pending → FLUSH. Else if iwb_stb_i → latch address, issue RAM read at index, → CMP.
- CMP: hit = valid & tag match. Hit → iwb_dat_o ← data RAM, iwb_ack_o=1 next cycle, → DONE. Miss → icb_stb_o=1, icb_adr_o=latched address, → FILL.
- FILL: hold icb_stb_o/icb_adr_o until icb_ack_i. On icb_ack_i: write {1,tag}/icb_dat_i at index, drop icb_stb_o, register icb_dat_i to iwb_dat_o, assert iwb_ack_o next cycle only if iwb_stb_i is still high and iwb_adr_i still equals latched address, → DONE.
- DONE: iwb_ack_o high this cycle only; → IDLE (or FLUSH if pending).
- Flush pending flag: set by ich_fls_i in any state, cleared on entering FLUSH. A flush during FILL waits for fill completion; the filled line is written, then invalidated by the sweep.
- Abandoned request (iwb_stb_i low in CMP or FILL): fill still completes and the line is written; no ack is issued.

## Timing
- Reset values: iwb_ack_o=0, iwb_dat_o=0, icb_stb_o=0, icb_adr_o=0, ich_bsy_o=1 (reset enters FLUSH, idx=0).
- Reset mid-fill: icb_stb_o=0 on the clock after sys_rst_i; a late icb_ack_i is ignored.
- Reset-to-ready: 2^CW cycles of FLUSH, then IDLE.
- Hit latency: stb sampled in IDLE at edge N; iwb_ack_o high during cycle N+2 (IDLE→CMP→DONE). Back-to-back hits: one ack per 3 cycles.
- Miss latency: icb_stb_o high from cycle N+2. iwb_ack_o is high the cycle after icb_ack_i is sampled.
- All outputs registered; no combinational input→output path.
- Simultaneous ich_fls_i and iwb_stb_i in IDLE: flush wins; the fetch is served after the sweep.

## Structure
- Shared package aemb_icache_pkg: state encoding enum, TW derivation function, line record (valid, tag).
- Sub-module aemb_icache_ram: parameterized sync-read single-port RAM, instantiated twice (tag, data).
- FSM, flush counter and bus registers live in aemb_icache.

## Test plan
- Reset, CW=4: ich_bsy_o=1 for exactly 16 cycles, iwb_stb_i ignored meanwhile, then 0.
- Cold fetch 0x40, memory returns 0xB8000010 after 3 cycles: icb_stb_o with icb_adr_o=0x10. iwb_ack_o pulses one cycle after icb_ack_i with iwb_dat_o=0xB8000010.
- Refetch 0x40: no icb_stb_o; ack at N+2 with the same data.
- Conflict, CW=4: fetch 0x40 then 0x80 (same index, different tag) → both miss. Then 0x40 misses again.
- ich_fls_i during FILL for 0x44: the fill completes and is acked, then a 16-cycle sweep runs. A following 0x44 fetch misses.
- Core drops iwb_stb_i during FILL: no iwb_ack_o is issued. A subsequent fetch of the same address hits.

Source files
------------

// File: rtl/aemb_icache_pkg.sv
// Shared types for the AEMB instruction cache: controller states, tag width helper, tag line record.
package aemb_icache_pkg;

  typedef enum logic [2:0] {FLUSH, IDLE, CMP, FILL, DONE} stateT;

  // Widest tag any legal AW/CW pairing can produce; narrower tags are zero-extended.
  localparam int TAG_MAX = 30;

  typedef struct packed {
    logic               valid;
    logic [TAG_MAX-1:0] tag;
  } lineT;

  function automatic int tagWidth(input int aw, input int cw);
    return aw - 2 - cw;
  endfunction

endpackage

// File: rtl/aemb_icache_ram.sv
// Single-port RAM with registered read; read-during-write returns the old contents.
module aemb_icache_ram #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] adr,
  input  logic [DW-1:0] dat,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[adr] <= dat;
    q <= mem[adr];
  end

endmodule

// File: rtl/aemb_icache.sv
// Direct-mapped, one-word-line instruction cache between the AEMB fetch port and the
// external instruction bus; misses become single-word classic reads.
module aemb_icache
  import aemb_icache_pkg::*;
#(
  parameter int AW = 32,
  parameter int CW = 8
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_i,
  input  logic          iwb_stb_i,
  input  logic [AW-3:0] iwb_adr_i,
  output logic [31:0]   iwb_dat_o,
  output logic          iwb_ack_o,
  output logic          icb_stb_o,
  output logic [AW-3:0] icb_adr_o,
  input  logic [31:0]   icb_dat_i,
  input  logic          icb_ack_i,
  input  logic          ich_fls_i,
  output logic          ich_bsy_o
);

  localparam int TW = tagWidth(AW, CW);

  stateT         state, nextState;
  logic [CW-1:0] flushIdx;
  logic          flsPend;
  logic          flushReq;
  logic [AW-3:0] reqAdr;
  logic [CW-1:0] ramAdr;
  logic          tagWe, datWe;
  logic [TW:0]   tagWr, tagRd;
  logic [31:0]   datRd;
  lineT          lineRd;
  logic          hit;
  logic          reqLive;

  aemb_icache_ram #(.DW(TW + 1), .AW(CW)) uTag (
    .clk(sys_clk_i), .we(tagWe), .adr(ramAdr), .dat(tagWr), .q(tagRd)
  );

  aemb_icache_ram #(.DW(32), .AW(CW)) uDat (
    .clk(sys_clk_i), .we(datWe), .adr(ramAdr), .dat(icb_dat_i), .q(datRd)
  );

  assign flushReq = flsPend | ich_fls_i;
  // Ack only if the core is still asking for the very word we looked up.
  assign reqLive  = iwb_stb_i && (iwb_adr_i == reqAdr);

  always_comb begin
    lineRd.valid = tagRd[TW];
    lineRd.tag   = TAG_MAX'(tagRd[TW-1:0]);
    hit          = lineRd.valid && (lineRd.tag == TAG_MAX'(reqAdr[AW-3:CW]));
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) state <= FLUSH;
    else           state <= nextState;
  end

  always_comb begin
    nextState = state;
    ramAdr    = iwb_adr_i[CW-1:0];
    tagWe     = 1'b0;
    datWe     = 1'b0;
    tagWr     = '0;
    case (state)
      FLUSH: begin
        ramAdr = flushIdx;
        tagWe  = 1'b1;
        if (&flushIdx) nextState = IDLE;
      end
      IDLE: begin
        if (flushReq)       nextState = FLUSH;
        else if (iwb_stb_i) nextState = CMP;
      end
      CMP: nextState = hit ? DONE : FILL;
      FILL: begin
        ramAdr = reqAdr[CW-1:0];
        if (icb_ack_i) begin
          tagWe     = 1'b1;
          datWe     = 1'b1;
          tagWr     = {1'b1, reqAdr[AW-3:CW]};
          nextState = DONE;
        end
      end
      DONE:    nextState = flushReq ? FLUSH : IDLE;
      default: nextState = FLUSH;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      flushIdx  <= '0;
      flsPend   <= 1'b0;
      reqAdr    <= '0;
      iwb_dat_o <= '0;
      iwb_ack_o <= 1'b0;
      icb_stb_o <= 1'b0;
      icb_adr_o <= '0;
      ich_bsy_o <= 1'b1;
    end else begin
      iwb_ack_o <= 1'b0;
      ich_bsy_o <= (nextState == FLUSH);
      if (nextState == FLUSH && state != FLUSH) flsPend <= 1'b0;
      else if (ich_fls_i)                       flsPend <= 1'b1;
      if (state == FLUSH) flushIdx <= flushIdx + CW'(1);
      case (state)
        IDLE: if (!flushReq && iwb_stb_i) reqAdr <= iwb_adr_i;
        CMP: begin
          if (hit) begin
            iwb_dat_o <= datRd;
            iwb_ack_o <= reqLive;
          end else begin
            icb_stb_o <= 1'b1;
            icb_adr_o <= reqAdr;
          end
        end
        FILL: begin
          if (icb_ack_i) begin
            icb_stb_o <= 1'b0;
            iwb_dat_o <= icb_dat_i;
            iwb_ack_o <= reqLive;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aemb_icache.sv
// Scoreboard bench for aemb_icache (CW=4): directed fetches, a latency-3 memory model
// and an ack monitor that pops expected instruction words.
module tb_aemb_icache;

  logic        sys_clk_i = 1'b0;
  logic        sys_rst_i;
  logic        iwb_stb_i;
  logic [29:0] iwb_adr_i;
  logic [31:0] iwb_dat_o;
  logic        iwb_ack_o;
  logic        icb_stb_o;
  logic [29:0] icb_adr_o;
  logic [31:0] icb_dat_i;
  logic        icb_ack_i;
  logic        ich_fls_i;
  logic        ich_bsy_o;

  aemb_icache #(.AW(32), .CW(4)) dut (
    .sys_clk_i(sys_clk_i), .sys_rst_i(sys_rst_i),
    .iwb_stb_i(iwb_stb_i), .iwb_adr_i(iwb_adr_i), .iwb_dat_o(iwb_dat_o), .iwb_ack_o(iwb_ack_o),
    .icb_stb_o(icb_stb_o), .icb_adr_o(icb_adr_o), .icb_dat_i(icb_dat_i), .icb_ack_i(icb_ack_i),
    .ich_fls_i(ich_fls_i), .ich_bsy_o(ich_bsy_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          reqCyc = 0;
  bit          chkLat = 0;
  bit          expFillAck = 1;
  bit          memHold = 0;
  bit          prevAck = 0;
  logic [31:0] ackExp [$];
  logic [29:0] icbExp [$];

  always @(posedge sys_clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Ack monitor: every ack must match the oldest expected word and last one cycle.
  always @(negedge sys_clk_i) begin
    if (iwb_ack_o) begin
      if (ackExp.size() == 0) begin
        tests++; fails++;
        $display("FAIL ackUnexpected: got ack with data %h, no ack expected", iwb_dat_o);
      end else begin
        chk("ackDat", iwb_dat_o, ackExp.pop_front());
      end
      chk("ackSingle", {31'd0, prevAck}, 32'd0);
    end
    prevAck = iwb_ack_o;
  end

  // External memory: word at address a holds 0xB8000000|a, answered 3 cycles after the strobe.
  initial begin
    logic [29:0] a;
    icb_ack_i = 1'b0;
    icb_dat_i = '0;
    forever begin
      @(negedge sys_clk_i);
      if (icb_stb_o && !memHold) begin
        a = icb_adr_o;
        if (icbExp.size() == 0) begin
          tests++; fails++;
          $display("FAIL icbUnexpected: got read of %h, none expected", a);
        end else begin
          chk("icbAdr", {2'b0, a}, {2'b0, icbExp.pop_front()});
        end
        chk("icbNotBusy", {31'd0, ich_bsy_o}, 32'd0);
        if (chkLat) chk("missLatency", cyc - reqCyc, 32'd2);
        repeat (2) @(negedge sys_clk_i);
        chk("icbStbHeld", {31'd0, icb_stb_o}, 32'd1);
        icb_dat_i = 32'hB800_0000 | {2'b0, a};
        icb_ack_i = 1'b1;
        @(negedge sys_clk_i);
        icb_ack_i = 1'b0;
        icb_dat_i = 32'hDEAD_BEEF;
        chk("ackAfterIcb", {31'd0, iwb_ack_o}, {31'd0, expFillAck});
        chk("icbStbDrop", {31'd0, icb_stb_o}, 32'd0);
      end
    end
  end

  task automatic waitAck(input string name);
    int n = 0;
    while (!iwb_ack_o && n < 200) begin
      @(negedge sys_clk_i);
      n++;
    end
    if (!iwb_ack_o) begin
      tests++; fails++;
      $display("FAIL %s: no ack within 200 cycles, expected one", name);
    end
  endtask

  task automatic waitIcb(input string name);
    int n = 0;
    while (!icb_stb_o && n < 200) begin
      @(negedge sys_clk_i);
      n++;
    end
    if (!icb_stb_o) begin
      tests++; fails++;
      $display("FAIL %s: no icb strobe within 200 cycles, expected one", name);
    end
  endtask

  task automatic countBusy(input string name, input int exp);
    int n = 0;
    while (ich_bsy_o && n < 200) begin
      n++;
      @(negedge sys_clk_i);
    end
    chk(name, n, exp);
  endtask

  // Issue one fetch from IDLE and hold it until acked.
  task automatic fetch(input logic [29:0] a, input logic [31:0] d, input bit miss);
    int n = 0;
    if (miss) icbExp.push_back(a);
    ackExp.push_back(d);
    expFillAck = 1;
    chkLat     = 1;
    reqCyc     = cyc;
    iwb_adr_i  = a;
    iwb_stb_i  = 1'b1;
    do begin
      @(negedge sys_clk_i);
      n++;
    end while (!iwb_ack_o && n < 200);
    if (!iwb_ack_o) begin
      tests++; fails++;
      $display("FAIL fetchTimeout: no ack for %h within 200 cycles", a);
    end else if (!miss) begin
      chk("hitLatency", n, 32'd2);
    end
    iwb_stb_i = 1'b0;
    @(negedge sys_clk_i);
  endtask

  initial begin
    sys_rst_i = 1'b1;
    iwb_stb_i = 1'b0;
    iwb_adr_i = '0;
    ich_fls_i = 1'b0;
    repeat (3) @(negedge sys_clk_i);
    chk("rstAck",    {31'd0, iwb_ack_o}, 32'd0);
    chk("rstDat",    iwb_dat_o, 32'd0);
    chk("rstIcbStb", {31'd0, icb_stb_o}, 32'd0);
    chk("rstIcbAdr", {2'b0, icb_adr_o}, 32'd0);
    chk("rstBsy",    {31'd0, ich_bsy_o}, 32'd1);

    // Fetch held through the reset sweep must wait until the sweep ends.
    icbExp.push_back(30'h30);
    ackExp.push_back(32'hB800_0030);
    chkLat    = 0;
    iwb_adr_i = 30'h30;
    iwb_stb_i = 1'b1;
    sys_rst_i = 1'b0;
    countBusy("rstSweepLen", 16);
    waitAck("sweepHeldFetch");
    iwb_stb_i = 1'b0;
    @(negedge sys_clk_i);

    fetch(30'h10, 32'hB800_0010, 1);  // cold 0x40, conflicts with 0xC0
    fetch(30'h10, 32'hB800_0010, 0);  // refetch hits
    fetch(30'h20, 32'hB800_0020, 1);  // 0x80: same index, other tag
    fetch(30'h10, 32'hB800_0010, 1);  // 0x40 evicted
    fetch(30'h10, 32'hB800_0010, 0);

    // Flush raised during the 0x44 fill: fill is acked, then a full sweep.
    icbExp.push_back(30'h11);
    ackExp.push_back(32'hB800_0011);
    expFillAck = 1;
    chkLat     = 1;
    reqCyc     = cyc;
    iwb_adr_i  = 30'h11;
    iwb_stb_i  = 1'b1;
    waitIcb("flushFillStb");
    ich_fls_i = 1'b1;
    @(negedge sys_clk_i);
    ich_fls_i = 1'b0;
    waitAck("flushFillAck");
    iwb_stb_i = 1'b0;
    @(negedge sys_clk_i);
    countBusy("flushSweepLen", 16);
    fetch(30'h11, 32'hB800_0011, 1);
    fetch(30'h10, 32'hB800_0010, 1);

    // Core abandons 0x48 mid-fill: no ack, but the line is still filled.
    icbExp.push_back(30'h12);
    expFillAck = 0;
    chkLat     = 1;
    reqCyc     = cyc;
    iwb_adr_i  = 30'h12;
    iwb_stb_i  = 1'b1;
    waitIcb("abandonStb");
    iwb_stb_i = 1'b0;
    repeat (8) @(negedge sys_clk_i);
    fetch(30'h12, 32'hB800_0012, 0);

    // Reset in the middle of a fill; the late external ack must be ignored.
    memHold   = 1;
    iwb_adr_i = 30'h40;
    iwb_stb_i = 1'b1;
    waitIcb("midFillStb");
    chk("midFillAdr", {2'b0, icb_adr_o}, 32'h40);
    iwb_stb_i = 1'b0;
    sys_rst_i = 1'b1;
    @(negedge sys_clk_i);
    sys_rst_i = 1'b0;
    chk("midRstIcbStb", {31'd0, icb_stb_o}, 32'd0);
    chk("midRstBsy",    {31'd0, ich_bsy_o}, 32'd1);
    icb_ack_i = 1'b1;
    icb_dat_i = 32'h1234_5678;
    @(negedge sys_clk_i);
    icb_ack_i = 1'b0;
    countBusy("midRstSweep", 15);
    repeat (4) @(negedge sys_clk_i);
    memHold = 0;
    fetch(30'h10, 32'hB800_0010, 1);  // reset invalidated every line

    repeat (4) @(negedge sys_clk_i);
    chk("ackQueueDrained", ackExp.size(), 32'd0);
    chk("icbQueueDrained", icbExp.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
